// File: rtl/pipelined_dual_port_ram.sv
// pipelined_dual_port_ram
//   Simple dual-port RAM (one write port, one read port, one clock) with a
//   READ_LATENCY-deep registered read pipeline, per-granule write masking,
//   selectable read-during-write behaviour and a sequential clear engine that
//   zeroes the array one word per cycle, so no parallel reset of the storage is
//   needed and the array can map onto SRAM macros.
//
// Ports
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   clear          request to zero the array (only honoured in READY)
//   busy           clear engine running; accesses are ignored
//   write_enable   write request
//   write_address  write word address
//   write_mask     bit i enables data bits [i*GRANULE +: GRANULE]
//   write_data     write data
//   read_enable    read request
//   read_address   read word address
//   read_data      read result, held between reads
//   read_valid     one-cycle pulse marking new read_data
//
// State | meaning
//   CLEAR | writing zero to memory[clear_count], busy=1
//   READY | normal read/write operation

module pipelined_dual_port_ram #(
    parameter int WIDTH             = 32,
    parameter int DEPTH             = 16,
    parameter int ADDRESS_WIDTH     = $clog2(DEPTH),
    parameter int GRANULE           = 8,
    parameter int READ_LATENCY      = 1,
    parameter int READ_DURING_WRITE = 0,
    parameter int CLEAR_ON_RESET    = 1,
    localparam int MASK_WIDTH       = WIDTH / GRANULE
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    output logic                     busy,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [MASK_WIDTH-1:0]    write_mask,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [WIDTH-1:0]         read_data,
    output logic                     read_valid
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(DEPTH - 1);
    // One extra bit so that DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] clear_count;

    logic [WIDTH-1:0]         memory [DEPTH];

    logic [READ_LATENCY-1:0][WIDTH-1:0] pipe_data;
    logic [READ_LATENCY-1:0]            pipe_valid;

    logic             write_in_range;
    logic             read_in_range;
    logic             write_accept;
    logic             read_accept;
    logic             collision;
    logic [WIDTH-1:0] write_old_word;
    logic [WIDTH-1:0] write_word;
    logic [WIDTH-1:0] read_old_word;
    logic [WIDTH-1:0] read_merged_word;
    logic [WIDTH-1:0] read_word;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= RESET_STATE;
            clear_count <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clear_count <= (clear_count == LAST_INDEX) ? '0 : clear_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clear_count == LAST_INDEX) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (clear) begin
                    next_state = CLEAR;
                end
            end
        endcase
    end

    // ---------------- access decode ----------------
    always_comb begin
        write_in_range = ({1'b0, write_address} < DEPTH_EXT);
        read_in_range  = ({1'b0, read_address} < DEPTH_EXT);
        write_accept   = write_enable && !busy && write_in_range;
        read_accept    = read_enable && !busy;
        collision      = write_accept && read_in_range && (write_address == read_address);

        write_old_word = '0;
        if (write_in_range) begin
            write_old_word = memory[write_address];
        end
        read_old_word = '0;
        if (read_in_range) begin
            read_old_word = memory[read_address];
        end

        write_word       = write_old_word;
        read_merged_word = read_old_word;
        for (int g = 0; g < MASK_WIDTH; g++) begin
            if (write_mask[g]) begin
                write_word[g*GRANULE +: GRANULE]       = write_data[g*GRANULE +: GRANULE];
                read_merged_word[g*GRANULE +: GRANULE] = write_data[g*GRANULE +: GRANULE];
            end
        end

        // Out-of-range reads yield zero via read_old_word's default.
        read_word = ((READ_DURING_WRITE != 0) && collision) ? read_merged_word : read_old_word;
    end

    // ---------------- storage (no reset: cleared by the engine) ----------------
    always_ff @(posedge clock) begin
        if (busy) begin
            memory[clear_count] <= '0;
        end else if (write_accept) begin
            memory[write_address] <= write_word;
        end
    end

    // ---------------- read pipeline ----------------
    // Stages keep shifting while busy so reads issued before a clear still complete.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_valid <= '0;
            pipe_data  <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            pipe_valid[0] <= read_accept;
            pipe_data[0]  <= read_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            read_valid <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) begin
                read_data <= pipe_data[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: doc/pipelined_dual_port_ram.md
# pipelined_dual_port_ram

Simple dual-port RAM (one write port, one read port, single clock) with registered, configurable-latency reads, per-granule write masking, selectable read-during-write behaviour and a sequential clear engine. The clear engine replaces a parallel reset of the array, so the block maps onto synthesised SRAM macros. It is the standard storage primitive for FIFOs, caches and register files that need more than one cycle of read timing slack.

## Interface
Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of GRANULE.
- DEPTH, 16, number of words; any value ≥ 2, not necessarily a power of two.
- ADDRESS_WIDTH, clog2(DEPTH), address width.
- GRANULE, 8, bits per write-mask bit; MASK_WIDTH = WIDTH/GRANULE.
- READ_LATENCY, 1, cycles from read issue to read_valid; legal range 1..4.
- READ_DURING_WRITE, 0, same-address collision mode: 0 = old data, 1 = new data.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = contents undefined after reset.

Ports:
- clock  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- clear  in  1  request to zero the whole array; sampled only in READY.
- busy  out  1  high while the clear engine runs; all accesses are ignored.
- write_enable  in  1  write request.
- write_address  in  ADDRESS_WIDTH  write word address.
- write_mask  in  MASK_WIDTH  bit i enables data bits [i*GRANULE +: GRANULE].
- write_data  in  WIDTH  write data.
- read_enable  in  1  read request.
- read_address  in  ADDRESS_WIDTH  read word address.
- read_data  out  WIDTH  read result; holds its value between reads.
- read_valid  out  1  one-cycle pulse marking new read_data.

## Operation
- Two-state FSM with states CLEAR and READY, plus a clear counter of ADDRESS_WIDTH bits.
- Reset:
  - Counter is set to 0.
  - State is CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - The read pipeline is flushed.
  - read_data=0 and read_valid=0; busy=CLEAR_ON_RESET.
- CLEAR:
  - Each cycle writes 0 to memory[counter], then increments the counter.
  - After writing index DEPTH-1, the FSM moves to READY and the counter returns to 0.
  - The clear takes exactly DEPTH cycles.
  - busy=1 for the whole state.
  - clear, write_enable and read_enable are ignored.
- READY:
  - clear=1 moves the FSM to CLEAR on the next edge. Any access presented in that same cycle is still performed.
- Write: when write_enable=1 and not busy, masked granules of memory[write_address] are updated at the edge. Unmasked granules are kept. A write with mask=0 is a no-op.
- Read: when read_enable=1 and not busy:
  - The array is sampled into pipeline stage 1.
  - The value shifts through READ_LATENCY stages. Each stage carries a valid bit.
  - read_data updates only when the last stage is valid.
- Collision (write and read enabled to the same address in the same cycle):
  - READ_DURING_WRITE=0: the read returns pre-write contents.
  - READ_DURING_WRITE=1: masked granules come from write_data and unmasked granules from the old contents.
- Address ≥ DEPTH: the write is dropped. The read returns 0 and still raises read_valid.
- Reads issued before a clear starts complete normally with their sampled data. Their read_valid still pulses during busy.

## Timing
- A read issued at edge N gives read_valid=1 and the data during cycle N+READ_LATENCY.
- Back-to-back reads are sustained at 1 per cycle; the pipeline has no stalls and no backpressure.
- A write at edge N is visible to reads issued at edge N+1 or later. A read issued at edge N itself follows the collision rule.
- The first accepted access after a clear is at the edge following busy falling.
- Reset asserted mid-operation:
  - Outputs go to their reset values immediately.
  - In-flight reads are lost, with no read_valid.
  - The clear restarts from index 0 after resetn rises.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=16: busy high for 16 cycles after resetn rises. Reading all 16 words then returns 0x00000000, with read_valid exactly 1 cycle after each read.
- READ_LATENCY=3: write 0xDEADBEEF to address 5, then read address 5. read_valid pulses once, 3 cycles after issue, with read_data=0xDEADBEEF. read_data still holds that value 10 cycles later.
- Masking: write 0x11223344 to address 2, then 0xAABBCCDD with mask 4'b0101. A read of address 2 returns 0x11BB33DD.
- Collision at address 7 holding 0x0 (write 0xFFFFFFFF, mask 4'b1111, same-cycle read): READ_DURING_WRITE=0 returns 0x00000000 and READ_DURING_WRITE=1 returns 0xFFFFFFFF. A following read of address 7 returns 0xFFFFFFFF in both modes.
- Clear request with DEPTH=12 and data present: assert clear for one cycle. busy is high for 12 cycles and accesses during that time are ignored. Addresses 0..11 then read 0, and address 13 reads 0 with read_valid=1.
- Reset mid-clear and mid-read: a read is in flight when resetn falls. No read_valid is produced, read_data=0, and a full DEPTH-cycle clear follows.
